sixteen_by_eight_seq_divider: RTL and testbench

//  Sequential restoring divider: the inverse operation of the 8x8 Wallace tree multipliers.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_restoring_step.sv | 26 ++
 rtl/sixteen_by_eight_seq_divider.sv | 117 +++++++++++
 tb/tb_sixteen_by_eight_seq_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
//  div_pkg : shared constants and state encoding for the 16/8 sequential divider
//  Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = DIVIDEND_W - DIVISOR_W;

  localparam logic [7:0] ERR_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_restoring_step.sv
// ============================================================================
//  div_restoring_step : one combinational restoring-division iteration
//  Revision: 1.0
// ============================================================================
`default_nettype none

module div_restoring_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] r_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 qbit
);

  logic [DIVISOR_W:0] t;

  assign t    = {r_in, bit_in};
  assign qbit = (t >= {1'b0, d});
  // The true difference is below d, so modular subtraction in DIVISOR_W bits is exact.
  assign r_out = qbit ? (t[DIVISOR_W-1:0] - d) : t[DIVISOR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/sixteen_by_eight_seq_divider.sv
// ============================================================================
//  sixteen_by_eight_seq_divider : restoring divider, one quotient bit per clock,
//  with start/busy/done handshake and divide-by-zero / overflow detection.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sixteen_by_eight_seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg::DIVISOR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [DIVIDEND_W-1:0]            dividend,
  input  logic [DIVISOR_W-1:0]             divisor,
  output logic                             busy,
  output logic                             done,
  output logic [DIVIDEND_W-DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]             remainder,
  output logic                             div_zero,
  output logic                             overflow
);

  localparam int QW = DIVIDEND_W - DIVISOR_W;
  localparam int CW = (DIVISOR_W > 1) ? $clog2(DIVISOR_W) : 1;

  div_state_e           state, state_next;
  logic [DIVISOR_W-1:0] dvs;
  logic [DIVISOR_W-1:0] prem;
  logic [QW-1:0]        qsr;
  logic [CW-1:0]        cnt;

  logic                 in_zero;
  logic                 in_ovf;
  logic                 last_iter;
  logic [DIVISOR_W-1:0] step_rem;
  logic                 step_qbit;

  assign in_zero   = (divisor == '0);
  assign in_ovf    = !in_zero && (dividend[DIVIDEND_W-1:QW] >= divisor);
  assign last_iter = (cnt == CW'(DIVISOR_W - 1));

  div_restoring_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_in   (prem),
    .bit_in (qsr[QW-1]),
    .d      (dvs),
    .r_out  (step_rem),
    .qbit   (step_qbit)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (in_zero || in_ovf) ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dvs       <= '0;
      prem      <= '0;
      qsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            if (in_zero || in_ovf) begin
              quotient  <= QW'(ERR_QUOT);
              remainder <= '0;
              div_zero  <= in_zero;
              overflow  <= in_ovf;
            end else begin
              dvs  <= divisor;
              prem <= dividend[DIVIDEND_W-1:QW];
              qsr  <= dividend[QW-1:0];
              cnt  <= '0;
            end
          end
        end
        CALC: begin
          prem <= step_rem;
          qsr  <= {qsr[QW-2:0], step_qbit};
          cnt  <= cnt + 1'b1;
          // Results are only published on the DONE-entry edge so outputs never show partials.
          if (last_iter) begin
            quotient  <= {qsr[QW-2:0], step_qbit};
            remainder <= step_rem;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_sixteen_by_eight_seq_divider.sv
// ============================================================================
//  tb_sixteen_by_eight_seq_divider : vector table + scoreboard bench for the divider
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sixteen_by_eight_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  sixteen_by_eight_seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest accepted request.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient",  {24'd0, quotient},  {24'd0, e.q});
        check("remainder", {24'd0, remainder}, {24'd0, e.r});
        check("div_zero",  {31'd0, div_zero},  {31'd0, e.dz});
        check("overflow",  {31'd0, overflow},  {31'd0, e.ov});
      end
    end
  end

  task automatic run_op(input vec_t v);
    int lat;
    bit got;
    lat = (v.dz || v.ov) ? 1 : 9;
    got = 1'b0;
    start    = 1'b1;
    dividend = v.dvd;
    divisor  = v.dvs;
    sb.push_back('{q: v.q, r: v.r, dz: v.dz, ov: v.ov});
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("busy_during", {31'd0, busy}, 32'd1);
      if (done) begin
        check("latency", k, lat);
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("idle_after", {30'd0, busy, done}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{16'd30000,  8'd150, 8'd200, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{16'd65025,  8'd255, 8'd255, 8'd0, 1'b0, 1'b0};
    vecs[2]  = '{16'd30001,  8'd150, 8'd200, 8'd1, 1'b0, 1'b0};
    vecs[3]  = '{16'h1234,   8'd0,   8'hFF,  8'd0, 1'b1, 1'b0};
    vecs[4]  = '{16'd25600,  8'd100, 8'hFF,  8'd0, 1'b0, 1'b1};
    vecs[5]  = '{16'd1000,   8'd7,   8'd142, 8'd6, 1'b0, 1'b0};
    vecs[6]  = '{16'd255,    8'd1,   8'd255, 8'd0, 1'b0, 1'b0};
    vecs[7]  = '{16'd0,      8'd9,   8'd0,   8'd0, 1'b0, 1'b0};
    vecs[8]  = '{16'h0100,   8'd1,   8'hFF,  8'd0, 1'b0, 1'b1};
    vecs[9]  = '{16'h08FF,   8'd9,   8'd255, 8'd8, 1'b0, 1'b0};
    vecs[10] = '{16'h0000,   8'd0,   8'hFF,  8'd0, 1'b1, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_outs", {14'd0, quotient, remainder, div_zero, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Starts while busy and in the DONE cycle are dropped; the next cycle accepts.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    sb.push_back('{q: 8'd142, r: 8'd6, dz: 1'b0, ov: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9 || k == 10);
      if (start) begin
        dividend = 16'd50;
        divisor  = 8'd5;
      end
      if (k == 8)  check("t5_not_done_8", {31'd0, done}, 32'd0);
      if (k == 9)  check("t5_done_9", {31'd0, done}, 32'd1);
      if (k == 10) begin
        check("t5_idle_10", {31'd0, busy}, 32'd0);
        sb.push_back('{q: 8'd10, r: 8'd0, dz: 1'b0, ov: 1'b0});
      end
      if (k == 19) check("t5_second_done", {31'd0, done}, 32'd1);
    end
    start = 1'b0;

    // Reset mid-operation abandons the result with no done pulse.
    start    = 1'b1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_done", {31'd0, done}, 32'd0);
    check("t6_outs", {14'd0, quotient, remainder, div_zero, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    run_op('{16'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0});

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
